// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 single-precision divider, restoring radix-2, one quotient bit per cycle
module fp_div_seq #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000,
  parameter int          QBITS     = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        zer,
  output logic        inf,
  output logic        nan
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;
  state_t state, nxt;
  logic [31:0] a, b;
  logic [2:0] rm;
  logic [24:0] rem, my;
  logic [25:0] q;
  logic [4:0] cnt;
  logic signed [9:0] e, er;
  logic sgn, za, zb, na, nb, ia, ib, is_nan, is_inf, is_zer, special;
  logic ge, n, g, s, inc, ovf, unf;
  logic [23:0] nr, mant, sum;
  logic [31:0] res_z;
  logic [4:0] res_f;
  assign sgn = a[31] ^ b[31];
  assign za = a[30:23] == 8'h00;
  assign zb = b[30:23] == 8'h00;
  assign na = &a[30:23] & |a[22:0];
  assign nb = &b[30:23] & |b[22:0];
  assign ia = &a[30:23] & ~|a[22:0];
  assign ib = &b[30:23] & ~|b[22:0];
  assign is_nan = na | nb | (za & zb) | (ia & ib);
  assign is_inf = ~is_nan & (ia | zb);
  assign is_zer = ~is_nan & ~is_inf & (za | ib);
  assign special = is_nan | is_inf | is_zer;
  assign my = {2'b01, b[22:0]};
  assign ge = rem >= my;
  assign nr = 24'(ge ? rem - my : rem);
  assign n = q[25];
  assign mant = n ? q[25:2] : q[24:1];
  assign g = n ? q[1] : q[0];
  assign s = (n & q[0]) | |rem;
  // sum wraps to 0 only on carry-out; otherwise its msb is the hidden 1
  assign sum = mant + 24'(inc);
  assign er = e - 10'(~n) + 10'(~sum[23]);
  assign ovf = er >= 10'sd255;
  assign unf = er <= 10'sd0;
  assign busy = state == PREP || state == ITER || state == ROUND;
  assign done = state == DONE;
  always_comb begin
    inc = rm == 3'd1 ? 1'b0 : rm == 3'd2 ? sgn & (g | s) : rm == 3'd3 ? ~sgn & (g | s) :
          rm == 3'd4 ? g : g & (s | mant[0]);
    res_z = state == PREP ? (is_nan ? CANON_NAN : is_inf ? {sgn, 8'hFF, 23'h0} : {sgn, 31'h0}) :
            ovf ? {sgn, 8'hFF, 23'h0} : unf ? {sgn, 31'h0} : {sgn, er[7:0], sum[22:0]};
    res_f = state == PREP ? {2'b00, is_zer, is_inf, is_nan} : {ovf, ~ovf & unf, ~ovf & unf, ovf, 1'b0};
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? PREP : IDLE;
      PREP:    nxt = special ? DONE : ITER;
      ITER:    nxt = cnt == 5'(QBITS - 1) ? ROUND : ITER;
      ROUND:   nxt = DONE;
      default: nxt = start ? PREP : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      rm <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      e <= '0;
    end else begin
      if (start && !busy) begin
        a <= fp_X;
        b <= fp_Y;
        rm <= r_mode;
      end
      if (state == PREP) begin
        rem <= {2'b01, a[22:0]};
        q <= '0;
        cnt <= '0;
        e <= 10'(a[30:23]) - 10'(b[30:23]) + 10'sd127;
      end
      if (state == ITER) begin
        q <= {q[24:0], ge};
        rem <= {nr, 1'b0};
        cnt <= cnt + 5'd1;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {fp_Z, ovrf, udrf, zer, inf, nan} <= '0;
    else if ((state == PREP && special) || state == ROUND) {fp_Z, ovrf, udrf, zer, inf, nan} <= {res_z, res_f};
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed vector table, corner sequences and randomized checks against an arithmetic model
module tb_fp_div_seq;
  logic clk = 0, rst_n = 1, start = 0;
  logic [31:0] fp_X = 0, fp_Y = 0, fp_Z;
  logic [2:0] r_mode = 0;
  logic busy, done, ovrf, udrf, zer, inf, nan;
  int n_chk = 0, n_fail = 0;

  fp_div_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
                  .busy(busy), .done(done), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .zer(zer), .inf(inf), .nan(nan));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y;
    logic [2:0]  rm;
    logic [31:0] z;
    logic [4:0]  f;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  // expected {special, z, ovrf, udrf, zer, inf, nan} from exact integer division
  function automatic logic [37:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    logic sg, zx, zy, nx, ny, ix, iy, g, st, inc;
    int ex, ey, e;
    longint mx, my, q, r, mant;
    sg = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = ex == 0; zy = ey == 0;
    nx = ex == 255 && x[22:0] != 0; ny = ey == 255 && y[22:0] != 0;
    ix = ex == 255 && x[22:0] == 0; iy = ey == 255 && y[22:0] == 0;
    if (nx || ny || (zx && zy) || (ix && iy)) return {1'b1, 32'h7FC00000, 5'b00001};
    if (ix || zy) return {1'b1, sg, 8'hFF, 23'h0, 5'b00010};
    if (zx || iy) return {1'b1, sg, 31'h0, 5'b00100};
    mx = longint'({1'b1, x[22:0]});
    my = longint'({1'b1, y[22:0]});
    q = (mx << 25) / my;
    r = (mx << 25) % my;
    e = ex - ey + 127;
    if (mx >= my) begin
      mant = q >> 2; g = q[1]; st = q[0] | (r != 0);
    end else begin
      mant = q >> 1; g = q[0]; st = r != 0; e = e - 1;
    end
    case (rm)
      3'd1: inc = 0;
      3'd2: inc = sg & (g | st);
      3'd3: inc = !sg & (g | st);
      3'd4: inc = g;
      default: inc = g & (st | mant[0]);
    endcase
    mant = mant + longint'(inc);
    if (mant == 64'd16777216) begin mant = 64'd8388608; e = e + 1; end
    if (e >= 255) return {1'b0, sg, 8'hFF, 23'h0, 5'b10010};
    if (e <= 0) return {1'b0, sg, 31'h0, 5'b01100};
    return {1'b0, sg, 8'(e), mant[22:0], 5'b00000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called #1 after an edge inside cycle N+off of an operation
  task automatic wait_done(input int off, output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    for (int i = 1; i <= 100; i++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      if (done) begin lat = i + off; break; end
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                        output logic [31:0] z, output logic [4:0] f, output int lat, output int bcnt);
    @(negedge clk);
    fp_X = x; fp_Y = y; r_mode = rm; start = 1;
    @(posedge clk); #1;
    start = 0; fp_X = $urandom; fp_Y = $urandom; r_mode = 3'($urandom);
    wait_done(1, lat, bcnt);
    z = fp_Z;
    f = {ovrf, udrf, zer, inf, nan};
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    logic [22:0] fr;
    int k = $urandom_range(0, 15);
    ex = k == 0 ? 8'h00 : k == 1 ? 8'hFF : k < 5 ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154));
    fr = $urandom_range(0, 7) == 0 ? 23'h0 : 23'($urandom);
    return {1'($urandom), ex, fr};
  endfunction

  initial begin
    logic [31:0] z, rx, ry;
    logic [4:0] f;
    logic [2:0] rrm;
    logic [37:0] m;
    int lat, bcnt, dcnt;
    tbl.push_back('{x:32'h40C00000, y:32'h40000000, rm:3'd0, z:32'h40400000, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'h40400000, rm:3'd0, z:32'h3EAAAAAB, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'h40400000, rm:3'd1, z:32'h3EAAAAAA, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'h40400000, rm:3'd2, z:32'h3EAAAAAA, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'h40400000, rm:3'd3, z:32'h3EAAAAAB, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'h40400000, rm:3'd4, z:32'h3EAAAAAB, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'h40400000, rm:3'd5, z:32'h3EAAAAAB, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'hC0400000, rm:3'd3, z:32'hBEAAAAAA, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'hC0400000, rm:3'd2, z:32'hBEAAAAAB, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h3F800000, y:32'h00000000, rm:3'd0, z:32'h7F800000, f:5'b00010, lat:2});
    tbl.push_back('{x:32'h00000000, y:32'h00000000, rm:3'd0, z:32'h7FC00000, f:5'b00001, lat:2});
    tbl.push_back('{x:32'h7F800000, y:32'hFF800000, rm:3'd0, z:32'h7FC00000, f:5'b00001, lat:2});
    tbl.push_back('{x:32'h7F800001, y:32'h3F800000, rm:3'd0, z:32'h7FC00000, f:5'b00001, lat:2});
    tbl.push_back('{x:32'h3F800000, y:32'hFFC00000, rm:3'd1, z:32'h7FC00000, f:5'b00001, lat:2});
    tbl.push_back('{x:32'h80000000, y:32'h7F800000, rm:3'd0, z:32'h80000000, f:5'b00100, lat:2});
    tbl.push_back('{x:32'hFF800000, y:32'h40000000, rm:3'd0, z:32'hFF800000, f:5'b00010, lat:2});
    tbl.push_back('{x:32'hBF800000, y:32'h00000000, rm:3'd0, z:32'hFF800000, f:5'b00010, lat:2});
    tbl.push_back('{x:32'h00400000, y:32'h3F800000, rm:3'd0, z:32'h00000000, f:5'b00100, lat:2});
    tbl.push_back('{x:32'h7F000000, y:32'h3E800000, rm:3'd0, z:32'h7F800000, f:5'b10010, lat:29});
    tbl.push_back('{x:32'h7F000000, y:32'h3F000000, rm:3'd1, z:32'h7F800000, f:5'b10010, lat:29});
    tbl.push_back('{x:32'hFF000000, y:32'h3E800000, rm:3'd0, z:32'hFF800000, f:5'b10010, lat:29});
    tbl.push_back('{x:32'h7F7FFFFF, y:32'h3F800000, rm:3'd0, z:32'h7F7FFFFF, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h00800000, y:32'h40000000, rm:3'd0, z:32'h00000000, f:5'b01100, lat:29});
    tbl.push_back('{x:32'h00800000, y:32'h3F800000, rm:3'd0, z:32'h00800000, f:5'b00000, lat:29});
    tbl.push_back('{x:32'h00800000, y:32'h3FC00000, rm:3'd0, z:32'h00000000, f:5'b01100, lat:29});
    tbl.push_back('{x:32'h80800000, y:32'h40000000, rm:3'd0, z:32'h80000000, f:5'b01100, lat:29});
    tbl.push_back('{x:32'h00800000, y:32'h7F000000, rm:3'd0, z:32'h00000000, f:5'b01100, lat:29});

    #2 rst_n = 0;
    #1;
    chk("reset fp_Z", fp_Z, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset flags", 32'({ovrf, udrf, zer, inf, nan}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      run_op(tbl[i].x, tbl[i].y, tbl[i].rm, z, f, lat, bcnt);
      chk($sformatf("vec%0d z", i), z, tbl[i].z);
      chk($sformatf("vec%0d flags", i), 32'(f), 32'(tbl[i].f));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      if (i == 0) chk("busy cycles", 32'(bcnt), 32'd28);
    end

    // start held high: second op accepted in the DONE cycle of the first
    @(negedge clk);
    fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'd0; start = 1;
    @(posedge clk); #1;
    fp_X = 32'h3F800000; fp_Y = 32'h40400000;
    wait_done(1, lat, bcnt);
    chk("b2b first latency", 32'(lat), 32'd29);
    chk("b2b first z", fp_Z, 32'h40400000);
    @(posedge clk); #1;
    start = 0;
    chk("b2b accepted busy", 32'(busy), 32'h1);
    chk("b2b held z", fp_Z, 32'h40400000);
    wait_done(1, lat, bcnt);
    chk("b2b second latency", 32'(lat), 32'd29);
    chk("b2b second z", fp_Z, 32'h3EAAAAAB);

    // start pulsed while busy is ignored
    @(negedge clk);
    fp_X = 32'h3F800000; fp_Y = 32'hC0400000; r_mode = 3'd3; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    fp_X = 32'h0; fp_Y = 32'h0; r_mode = 3'd0; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(6, lat, bcnt);
    chk("ignore latency", 32'(lat), 32'd29);
    chk("ignore z", fp_Z, 32'hBEAAAAAA);
    chk("ignore flags", 32'({ovrf, udrf, zer, inf, nan}), 32'h0);
    dcnt = 0;
    repeat (35) begin @(posedge clk); #1; if (done || busy) dcnt++; end
    chk("ignore no extra op", 32'(dcnt), 32'd0);

    // reset in cycle N+10 aborts the divide
    @(negedge clk);
    fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'd0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort fp_Z", fp_Z, 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    dcnt = 0;
    repeat (35) begin @(posedge clk); #1; if (done) dcnt++; end
    chk("abort no done", 32'(dcnt), 32'd0);
    run_op(32'h3F800000, 32'h40400000, 3'd1, z, f, lat, bcnt);
    chk("after reset z", z, 32'h3EAAAAAA);
    chk("after reset latency", 32'(lat), 32'd29);

    for (int i = 0; i < 300; i++) begin
      rx = rand_fp();
      ry = rand_fp();
      rrm = 3'($urandom_range(0, 7));
      m = model(rx, ry, rrm);
      run_op(rx, ry, rrm, z, f, lat, bcnt);
      chk($sformatf("rand%0d %h/%h m%0d z", i, rx, ry, rrm), z, m[36:5]);
      chk($sformatf("rand%0d flags", i), 32'(f), 32'(m[4:0]));
      chk($sformatf("rand%0d latency", i), 32'(lat), m[37] ? 32'd2 : 32'd29);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
